// File: rtl/mmio_store_if.sv
// Store-side MMIO bus: committing store from X/M plus the byte handshake to the UART transmitter.
interface mmio_store_if #(
  parameter int W_SIZE = 32
);
  logic              store_valid;
  logic [W_SIZE-1:0] store_addr;
  logic [W_SIZE-1:0] store_data;
  logic [3:0]        store_mask;
  logic              store_stall;
  logic [7:0]        tx_data;
  logic              tx_data_valid;
  logic              tx_data_ready;

  modport master (
    output store_valid, store_addr, store_data, store_mask, tx_data_ready,
    input  store_stall, tx_data, tx_data_valid
  );

  modport slave (
    input  store_valid, store_addr, store_data, store_mask, tx_data_ready,
    output store_stall, tx_data, tx_data_valid
  );
endinterface

// File: rtl/mmio_store_ctrl.sv
// Write-direction MMIO controller: UART TX byte FIFO with ready/valid drain,
// plus cycle/instruction counters that are cleared by a store.
module mmio_store_ctrl #(
  parameter int                 W_SIZE       = 32,
  parameter int                 FIFO_DEPTH   = 4,
  parameter logic [W_SIZE-1:0]  UART_TX_ADDR = 'h8000_0008,
  parameter logic [W_SIZE-1:0]  CTR_RST_ADDR = 'h8000_0018
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_store_if.slave       bus,
  input  logic              inst_retire_i,
  output logic              tx_ready_status_o,
  output logic [W_SIZE-1:0] cycle_count_o,
  output logic [W_SIZE-1:0] inst_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [W_SIZE-1:0] cycle_q, cycle_d;
  logic [W_SIZE-1:0] inst_q, inst_d;

  logic tx_push_req, ctr_clr, full, empty, push, pop;
  logic unused_data_hi;

  assign unused_data_hi = ^bus.store_data[W_SIZE-1:8];

  assign tx_push_req = bus.store_valid && (bus.store_addr == UART_TX_ADDR) && bus.store_mask[0];
  assign ctr_clr     = bus.store_valid && (bus.store_addr == CTR_RST_ADDR) && (|bus.store_mask);

  // Full/empty come only from registered pointers so the stall never depends on tx_data_ready.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = tx_push_req && !full;
  assign pop   = !empty && bus.tx_data_ready;

  assign bus.store_stall   = tx_push_req && full;
  assign bus.tx_data_valid = !empty;
  assign bus.tx_data       = mem_q[rd_ptr_q[AW-1:0]];
  assign tx_ready_status_o = !full;
  assign cycle_count_o     = cycle_q;
  assign inst_count_o      = inst_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // A retiring clear store is itself not counted: clear wins over the increment.
  always_comb begin
    cycle_d = cycle_q + W_SIZE'(1);
    inst_d  = inst_q + W_SIZE'(inst_retire_i);
    if (ctr_clr) begin
      cycle_d = '0;
      inst_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cycle_q  <= '0;
      inst_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cycle_q  <= cycle_d;
      inst_q   <= inst_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.store_data[7:0];
    end
  end

endmodule
